// File: rtl/sobel_window_3x3.sv
// 3x3 neighbourhood generator for the Sobel stage: two row-deep line buffers
// feed a sliding 3x3 window register, with raster counters gating validity.
module sobel_window_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [DATA_WIDTH-1:0]          DataIn,
  input  logic                           Enable,
  output logic [9*DATA_WIDTH-1:0]        Window,
  output logic                           WindowValid,
  output logic [$clog2(IMG_WIDTH)-1:0]   ColCount,
  output logic [$clog2(IMG_HEIGHT)-1:0]  RowCount,
  output logic                           FrameDone
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_d [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_d [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  // Each line buffer is exactly one row deep, so its tail is the pixel
  // directly above the one being accepted.
  always_comb begin
    lb1_d = lb1_q;
    lb2_d = lb2_q;
    if (Enable) begin
      for (int i = IMG_WIDTH - 1; i > 0; i--) begin
        lb1_d[i] = lb1_q[i-1];
        lb2_d[i] = lb2_q[i-1];
      end
      lb1_d[0] = DataIn;
      lb2_d[0] = lb1_q[IMG_WIDTH-1];
    end
  end

  always_comb begin
    win_d = win_q;
    if (Enable) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r+1];
        win_d[3*r + 1] = win_q[3*r+2];
      end
      win_d[2] = lb2_q[IMG_WIDTH-1];
      win_d[5] = lb1_q[IMG_WIDTH-1];
      win_d[8] = DataIn;
    end
  end

  // Validity is decided from the position of the pixel being accepted, so
  // row-boundary and new-frame windows built from stale data are never flagged.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (Enable) begin
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    lb1_q <= lb1_d;
    lb2_q <= lb2_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q   <= '{default: '0};
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    Window = '0;
    for (int k = 0; k < 9; k++) begin
      Window[DATA_WIDTH*k +: DATA_WIDTH] = win_q[k];
    end
  end

  assign WindowValid = valid_q;
  assign ColCount    = col_q;
  assign RowCount    = row_q;
  assign FrameDone   = done_q;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Self-checking bench for sobel_window_3x3 on an 8x6 image, checked against a
// frame-array model that builds each expected window from raster coordinates.
module tb_sobel_window_3x3;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] DataIn;
  logic          Enable;
  logic [9*DW-1:0] Window;
  logic          WindowValid;
  logic [2:0]    ColCount;
  logic [2:0]    RowCount;
  logic          FrameDone;

  sobel_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .CLK(CLK), .RST(RST), .DataIn(DataIn), .Enable(Enable),
    .Window(Window), .WindowValid(WindowValid), .ColCount(ColCount),
    .RowCount(RowCount), .FrameDone(FrameDone)
  );

  always #5 CLK = ~CLK;

  int n_vectors = 0;
  int n_miss    = 0;

  // Reference model: the pixels of the current frame indexed by position.
  logic [DW-1:0]   img [H][W];
  int              mr = 0, mc = 0;
  logic            exp_valid, exp_done;
  logic [9*DW-1:0] exp_window;
  logic            accepted;

  // Drive one cycle, advance the model, then sample 1 ns after the edge.
  task automatic step(input logic rst, input logic en, input logic [DW-1:0] d);
    RST = rst; Enable = en; DataIn = d;
    accepted = 1'b0;
    if (rst) begin
      mr = 0; mc = 0;
      exp_valid = 1'b0; exp_done = 1'b0; exp_window = '0;
    end else if (en) begin
      accepted = 1'b1;
      img[mr][mc] = d;
      exp_valid = (mr >= 2) && (mc >= 2);
      exp_done  = (mr == H-1) && (mc == W-1);
      if (exp_valid)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_window[DW*(3*i+j) +: DW] = img[mr-2+i][mc-2+j];
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end else begin
      exp_valid = 1'b0; exp_done = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'hA5);
    n_vectors++;
    if (Window !== '0) begin
      n_miss++; $display("[TB] FAIL reset_window got %h exp 0", Window);
    end
    n_vectors++;
    if (WindowValid !== 1'b0 || FrameDone !== 1'b0) begin
      n_miss++; $display("[TB] FAIL reset_flags got valid=%b done=%b exp 0/0", WindowValid, FrameDone);
    end
    n_vectors++;
    if (ColCount !== 3'd0 || RowCount !== 3'd0) begin
      n_miss++; $display("[TB] FAIL reset_counters got r=%0d c=%0d exp 0/0", RowCount, ColCount);
    end
  endtask

  task automatic test_continuous_frame;
    int valids = 0;
    logic [9*DW-1:0] first_win;
    first_win = 72'h22_21_20_12_11_10_02_01_00;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b0, 1'b1, DW'(16*r + c));
        n_vectors++;
        if (WindowValid !== exp_valid) begin
          n_miss++; $display("[TB] FAIL cont_valid at (%0d,%0d) got %b exp %b", r, c, WindowValid, exp_valid);
        end
        if (exp_valid) begin
          valids++;
          n_vectors++;
          if (Window !== exp_window) begin
            n_miss++; $display("[TB] FAIL cont_window at (%0d,%0d) got %h exp %h", r, c, Window, exp_window);
          end
        end
        n_vectors++;
        if (ColCount !== 3'(mc) || RowCount !== 3'(mr) || FrameDone !== exp_done) begin
          n_miss++; $display("[TB] FAIL cont_counters got r=%0d c=%0d done=%b exp r=%0d c=%0d done=%b",
                             RowCount, ColCount, FrameDone, mr, mc, exp_done);
        end
        if (r == 2 && c == 2) begin
          n_vectors++;
          if (Window !== first_win || WindowValid !== 1'b1) begin
            n_miss++; $display("[TB] FAIL cont_first_window got %h valid=%b exp %h valid=1", Window, WindowValid, first_win);
          end
        end
      end
    end
    n_vectors++;
    if (valids != (W-2)*(H-2)) begin
      n_miss++; $display("[TB] FAIL cont_valid_count got %0d exp %0d", valids, (W-2)*(H-2));
    end
  endtask

  task automatic test_enable_gaps;
    int valids = 0, pix = 0, cycles = 0;
    int r, c;
    logic en;
    while (pix < W*H && cycles < 1000) begin
      en = 1'($urandom_range(0, 1));
      r = pix / W; c = pix % W;
      step(1'b0, en, en ? DW'(16*r + c) : DW'($urandom));
      cycles++;
      if (accepted) pix++;
      n_vectors++;
      if (WindowValid !== exp_valid) begin
        n_miss++; $display("[TB] FAIL gap_valid cycle %0d en=%b got %b exp %b", cycles, en, WindowValid, exp_valid);
      end
      if (exp_valid) begin
        valids++;
        n_vectors++;
        if (Window !== exp_window) begin
          n_miss++; $display("[TB] FAIL gap_window cycle %0d got %h exp %h", cycles, Window, exp_window);
        end
      end
    end
    n_vectors++;
    if (pix != W*H) begin
      n_miss++; $display("[TB] FAIL gap_timeout got %0d pixels exp %0d", pix, W*H);
    end
    n_vectors++;
    if (valids != (W-2)*(H-2)) begin
      n_miss++; $display("[TB] FAIL gap_valid_count got %0d exp %0d", valids, (W-2)*(H-2));
    end
  endtask

  task automatic test_frame_wrap;
    int dones = 0, early_valid = 0;
    logic [9*DW-1:0] f2_first;
    f2_first = 72'hA2_A1_A0_92_91_90_82_81_80;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          step(1'b0, 1'b1, DW'(128*f + 16*r + c));
          if (FrameDone === 1'b1) dones++;
          n_vectors++;
          if (FrameDone !== exp_done || WindowValid !== exp_valid) begin
            n_miss++; $display("[TB] FAIL wrap_flags f%0d (%0d,%0d) got done=%b valid=%b exp done=%b valid=%b",
                               f, r, c, FrameDone, WindowValid, exp_done, exp_valid);
          end
          if (f == 1 && r < 2 && WindowValid !== 1'b0) early_valid++;
          if (f == 1 && r == 2 && c == 2) begin
            n_vectors++;
            if (Window !== f2_first) begin
              n_miss++; $display("[TB] FAIL wrap_first_window got %h exp %h", Window, f2_first);
            end
          end
        end
      end
    end
    n_vectors++;
    if (dones != 2 || early_valid != 0) begin
      n_miss++; $display("[TB] FAIL wrap_counts got dones=%0d early_valid=%0d exp 2/0", dones, early_valid);
    end
  endtask

  task automatic test_reset_mid_frame;
    int valids = 0;
    for (int p = 0; p <= 3*W + 4; p++)
      step(1'b0, 1'b1, DW'(16*(p / W) + (p % W)));
    step(1'b1, 1'b1, 8'hEE);
    n_vectors++;
    if (ColCount !== 3'd0 || RowCount !== 3'd0 || WindowValid !== 1'b0 || Window !== '0) begin
      n_miss++; $display("[TB] FAIL midreset_state got r=%0d c=%0d valid=%b win=%h exp 0/0/0/0",
                         RowCount, ColCount, WindowValid, Window);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b0, 1'b1, DW'(8'h40 + 16*r + c));
        n_vectors++;
        if (WindowValid !== exp_valid || (exp_valid && Window !== exp_window)) begin
          n_miss++; $display("[TB] FAIL midreset_window (%0d,%0d) got valid=%b %h exp valid=%b %h",
                             r, c, WindowValid, Window, exp_valid, exp_window);
        end
        if (WindowValid === 1'b1) valids++;
      end
    end
    n_vectors++;
    if (valids != (W-2)*(H-2)) begin
      n_miss++; $display("[TB] FAIL midreset_valid_count got %0d exp %0d", valids, (W-2)*(H-2));
    end
  endtask

  task automatic test_max_value;
    int valids = 0;
    logic [9*DW-1:0] ones;
    ones = '1;
    for (int p = 0; p < W*H; p++) begin
      step(1'b0, 1'b1, 8'hFF);
      if (exp_valid) begin
        valids++;
        n_vectors++;
        if (Window !== ones || WindowValid !== 1'b1) begin
          n_miss++; $display("[TB] FAIL max_window pixel %0d got %h valid=%b exp %h valid=1", p, Window, WindowValid, ones);
        end
      end
    end
    n_vectors++;
    if (valids != (W-2)*(H-2)) begin
      n_miss++; $display("[TB] FAIL max_valid_count got %0d exp %0d", valids, (W-2)*(H-2));
    end
  endtask

  initial begin
    RST = 1'b1; Enable = 1'b0; DataIn = '0;
    exp_valid = 1'b0; exp_done = 1'b0; exp_window = '0;
    test_reset;
    test_continuous_frame;
    test_enable_gaps;
    test_frame_wrap;
    test_reset_mid_frame;
    test_max_value;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end

endmodule
